// File: rtl/detector_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | detector_seq_ctrl: shifts a word MSB-first into a serial pattern detector |
// | and reports match count and first-match bit index.   Revision: 1.0       |
// +--------------------------------------------------------------------------+
module detector_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = $clog2(WIDTH + 1),
  parameter int POS_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_a,
  output logic             det_reset,
  input  logic             det_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [POS_W-1:0] out_first
);

  localparam int               CYC_W        = $clog2(WIDTH + DET_LAT + 1);
  localparam logic [CYC_W-1:0] LAST_CYC     = CYC_W'(WIDTH + DET_LAT - 1);
  localparam logic [CYC_W-1:0] FIRST_SAMPLE = CYC_W'(DET_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit_q, hit_d;
  logic [POS_W-1:0] first_q, first_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             det_a_q, det_a_d;
  logic             det_reset_q, det_reset_d;
  logic [POS_W-1:0] sample_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cyc_q       <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      first_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      det_a_q     <= 1'b0;
      det_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cyc_q       <= cyc_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      det_a_q     <= det_a_d;
      det_reset_q <= det_reset_d;
    end
  end

  // All outputs are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cyc_d       = cyc_q;
    count_d     = count_q;
    hit_d       = hit_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    in_ready_d  = 1'b0;
    det_a_d     = 1'b0;
    det_reset_d = 1'b0;
    sample_idx  = POS_W'(cyc_q - FIRST_SAMPLE);

    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d     = S_FLUSH;
          shift_d     = in_data;
          count_d     = '0;
          hit_d       = 1'b0;
          first_d     = '0;
          in_ready_d  = 1'b0;
          det_reset_d = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_SHIFT;
        cyc_d   = '0;
        det_a_d = shift_q[WIDTH-1];
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end
      S_SHIFT: begin
        // Response for bit j arrives DET_LAT cycles after it was driven.
        if ((cyc_q >= FIRST_SAMPLE) && det_w) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == '0) begin
            hit_d   = 1'b1;
            first_d = sample_idx;
          end
        end
        if (cyc_q == LAST_CYC) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          // Zeros shifted in behind the word form the drain bits.
          cyc_d   = cyc_q + CYC_W'(1);
          det_a_d = shift_q[WIDTH-1];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign det_a     = det_a_q;
  assign det_reset = det_reset_q;
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign out_hit   = hit_q;
  assign out_first = first_q;

endmodule
`default_nettype wire
